kernel_nios2_cpu_debug_monitor_ctrl: RTL and testbench
======================================================

KERNEL_NIOS2_CPU_DEBUG_MONITOR_CTRL -- requirements
Module: kernel_nios2_cpu_debug_monitor_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 8, word-address width of the debug monitor RAM (2^ADDR_W x 32 bits).
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 Port: clk, input, 1, system clock; all logic on rising edge.
REQ-004 Port: reset, input, 1, asynchronous active-high reset.
REQ-005 Port: jdo, input, 38, JTAG debug-slave data word, sampled only with a take_* strobe.
REQ-006 Port: take_action_ocimem_a, input, 1, one-cycle strobe for an address-load command.
REQ-007 Port: take_action_ocimem_b, input, 1, one-cycle strobe for a data-write command.
REQ-008 Port: take_no_action_ocimem_a, input, 1, one-cycle strobe for a read-next command.
REQ-009 Port: cpu_address, input, ADDR_W, CPU-side word address.
REQ-010 Port: cpu_read / cpu_write, input, 1 each, CPU-side access requests; never both high.
REQ-011 Port: cpu_writedata, input, 32, CPU write data.
REQ-012 Port: cpu_readdata, output, 32, CPU read data; valid when cpu_read=1 and cpu_waitrequest=0.
REQ-013 Port: cpu_waitrequest, output, 1, CPU stall.
REQ-014 Port: MonDReg, output, 32, monitor data register returned to the debug slave.
REQ-015 Port: MonAReg, output, ADDR_W, monitor address register.
REQ-016 Port: monitor_ready, output, 1, high when the controller can accept a debug command.
REQ-017 Port: monitor_error, output, 1, sticky command-overrun flag.

Function
REQ-018 FSM states: IDLE, DBG_RD, DBG_RDLAT, DBG_WR, CPU_RD; all non-IDLE states return to IDLE after one cycle.
REQ-019 Command priority, if strobes coincide: ocimem_a > ocimem_b > no_action_a; lower-priority strobes are dropped and monitor_error is set.
REQ-020 ocimem_a in IDLE: MonAReg <= jdo[ADDR_W+16:17]; jdo[34]=1 clears monitor_error; jdo[35]=1 -> DBG_RD; else remain IDLE.
REQ-021 ocimem_b in IDLE: MonDReg <= jdo[34:3]; -> DBG_WR; in DBG_WR, the RAM is written with MonDReg at MonAReg.
REQ-022 no_action_ocimem_a in IDLE: -> DBG_RD at the current MonAReg.
REQ-023 Read timing: strobe at cycle N; RAM read at N+1 (DBG_RD); MonDReg captures RAM data at the end of N+2 (DBG_RDLAT); MonDReg is valid and monitor_ready=1 at N+3.
REQ-024 Write timing: strobe at cycle N; RAM written at N+1; monitor_ready=1 at N+2.
REQ-025 monitor_ready is 0 in every non-IDLE state and in the cycle after an accepted command.
REQ-026 MonAReg post-increments mod 2^ADDR_W at completion of every debug read and write; with ADDR_W=8, 0xFF wraps to 0x00.
REQ-027 Any take_* strobe while not IDLE is ignored and sets monitor_error, which stays set until cleared per REQ-020.
REQ-028 CPU write in IDLE with no debug strobe: the RAM is written the same cycle with cpu_waitrequest=0; otherwise cpu_waitrequest=1.
REQ-029 CPU read in IDLE with no debug strobe: -> CPU_RD with cpu_waitrequest=1; in CPU_RD, cpu_readdata is valid and cpu_waitrequest=0.
REQ-030 A debug strobe in the same cycle as a CPU request wins; the CPU stalls (cpu_waitrequest=1) until the next IDLE.
REQ-031 CPU accesses never modify MonAReg, MonDReg or monitor_error.

Reset
REQ-032 While reset=1: FSM=IDLE, MonDReg=0, MonAReg=0, monitor_ready=1, monitor_error=0, cpu_readdata=0, cpu_waitrequest=1.
REQ-033 Reset mid-operation aborts any access without a RAM write; RAM contents are not cleared.
REQ-034 The first command is accepted in the first cycle after reset deasserts.

Structure
REQ-035 Shared package kernel_nios2_debug_pkg holds: the FSM state enum; jdo field positions (35 read-enable, 34 error-clear/data MSB, ADDR_W+16:17 address, 34:3 data); ADDR_W default.
REQ-036 One sub-module, kernel_nios2_cpu_debug_monitor_ram: single-port 2^ADDR_W x 32 RAM with a 1-cycle synchronous read; the controller muxes the port between debug and CPU.

Verification
REQ-037 Write then read: ocimem_a(jdo addr=0x10, jdo[35]=0); ocimem_b(data 0xDEADBEEF); ocimem_a(addr=0x10, jdo[35]=1) -> MonDReg=0xDEADBEEF exactly 3 cycles after the last strobe; MonAReg=0x11.
REQ-038 Wrap: ocimem_a(addr=0xFF); ocimem_b(0x12345678) -> MonAReg=0x00; a CPU read of 0xFF returns 0x12345678.
REQ-039 Overrun: no_action_a, then ocimem_b one cycle later -> second command ignored, monitor_error=1; ocimem_a with jdo[34]=1 -> monitor_error=0.
REQ-040 Collision: cpu_write(0x20, 0xA5A5A5A5) in the same cycle as no_action_a -> cpu_waitrequest=1 until IDLE, then the write completes; the debug read is unaffected.
REQ-041 Reset mid-read: assert reset in DBG_RDLAT -> all outputs at reset values next cycle; MonDReg=0 and RAM is unchanged.
REQ-042 Strobe coincidence: ocimem_a and ocimem_b in the same cycle -> only the address load occurs, monitor_error=1, and no RAM write.

Source files
------------

// File: rtl/kernel_nios2_debug_pkg.sv
// Shared definitions for the Nios II debug monitor controller: FSM states,
// JTAG debug word (jdo) field positions and the default RAM address width.
package kernel_nios2_debug_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int JDO_W          = 38;

  // jdo field positions
  localparam int JDO_RD_EN_BIT   = 35;  // address-load: follow with a read
  localparam int JDO_ERR_CLR_BIT = 34;  // address-load: clear monitor_error
  localparam int JDO_ADDR_LSB    = 17;  // address field is jdo[ADDR_W+16:17]
  localparam int JDO_DATA_MSB    = 34;
  localparam int JDO_DATA_LSB    = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DBG_RD    = 3'd1,
    ST_DBG_RDLAT = 3'd2,
    ST_DBG_WR    = 3'd3,
    ST_CPU_RD    = 3'd4
  } mon_state_t;

  // Data payload carried by a data-write command.
  function automatic logic [31:0] jdo_data(input logic [JDO_W-1:0] jdo);
    return jdo[JDO_DATA_MSB:JDO_DATA_LSB];
  endfunction

endpackage

// File: rtl/kernel_nios2_cpu_debug_monitor_ram.sv
// Single-port 2^ADDR_W x 32 monitor RAM with a one-cycle synchronous read.
// Contents are intentionally not reset.
module kernel_nios2_cpu_debug_monitor_ram
  import kernel_nios2_debug_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(2**ADDR_W)-1];

  // Write port and registered read of the addressed word (read-before-write).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/kernel_nios2_cpu_debug_monitor_ctrl.sv
// Debug monitor controller: arbitrates the monitor RAM between JTAG debug
// commands (address load, data write, read-next) and CPU accesses. Debug
// strobes always win; the CPU is stalled until the controller is idle again.
module kernel_nios2_cpu_debug_monitor_ctrl
  import kernel_nios2_debug_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  mon_state_t        state;
  logic              any_strobe;
  logic              cpu_wr_ok;
  logic              cpu_rd_ok;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              unused_jdo_bits;

  assign any_strobe      = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // jdo bits outside every command field carry no meaning here
  assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

  kernel_nios2_cpu_debug_monitor_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // CPU handshake and RAM port mux: debug states own the port, CPU uses it in IDLE/CPU_RD.
  always_comb begin
    cpu_wr_ok = 1'b0;
    cpu_rd_ok = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cpu_address;
    ram_wdata = cpu_writedata;
    case (state)
      ST_IDLE: begin
        cpu_wr_ok = cpu_write & ~any_strobe & ~reset;
        ram_we    = cpu_wr_ok;
      end
      ST_DBG_RD: begin
        ram_addr = MonAReg;
      end
      ST_DBG_WR: begin
        ram_addr  = MonAReg;
        ram_wdata = MonDReg;
        ram_we    = ~reset;
      end
      ST_CPU_RD: begin
        cpu_rd_ok = cpu_read & ~reset;
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
    cpu_waitrequest = ~(cpu_wr_ok | cpu_rd_ok);
    if (state == ST_CPU_RD) begin
      cpu_readdata = ram_rdata;
    end else begin
      cpu_readdata = 32'h0000_0000;
    end
  end

  // Command FSM with registered monitor outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      MonDReg       <= 32'h0000_0000;
      MonAReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_action_ocimem_a) begin
            // an error clear and a same-cycle dropped strobe: the new overrun wins
            MonAReg       <= jdo[JDO_ADDR_LSB +: ADDR_W];
            monitor_error <= (monitor_error & ~jdo[JDO_ERR_CLR_BIT])
                             | take_action_ocimem_b | take_no_action_ocimem_a;
            monitor_ready <= 1'b0;
            state         <= jdo[JDO_RD_EN_BIT] ? ST_DBG_RD : ST_IDLE;
          end else if (take_action_ocimem_b) begin
            MonDReg       <= jdo_data(jdo);
            monitor_error <= monitor_error | take_no_action_ocimem_a;
            monitor_ready <= 1'b0;
            state         <= ST_DBG_WR;
          end else if (take_no_action_ocimem_a) begin
            monitor_ready <= 1'b0;
            state         <= ST_DBG_RD;
          end else if (cpu_read) begin
            monitor_ready <= 1'b0;
            state         <= ST_CPU_RD;
          end else begin
            monitor_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        ST_DBG_RD: begin
          monitor_error <= monitor_error | any_strobe;
          state         <= ST_DBG_RDLAT;
        end
        ST_DBG_RDLAT: begin
          monitor_error <= monitor_error | any_strobe;
          MonDReg       <= ram_rdata;
          MonAReg       <= MonAReg + ADDR_W'(1);
          monitor_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        ST_DBG_WR: begin
          monitor_error <= monitor_error | any_strobe;
          MonAReg       <= MonAReg + ADDR_W'(1);
          monitor_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        ST_CPU_RD: begin
          monitor_error <= monitor_error | any_strobe;
          monitor_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        default: begin
          monitor_ready <= 1'b1;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_nios2_cpu_debug_monitor_ctrl.sv
// Self-checking bench: directed scenarios plus randomized transactions,
// compared against a transaction-level model (array RAM + register values).
module tb_kernel_nios2_cpu_debug_monitor_ctrl;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          take_action_ocimem_a;
  logic          take_action_ocimem_b;
  logic          take_no_action_ocimem_a;
  logic [AW-1:0] cpu_address;
  logic          cpu_read;
  logic          cpu_write;
  logic [31:0]   cpu_writedata;
  logic [31:0]   cpu_readdata;
  logic          cpu_waitrequest;
  logic [31:0]   MonDReg;
  logic [AW-1:0] MonAReg;
  logic          monitor_ready;
  logic          monitor_error;

  kernel_nios2_cpu_debug_monitor_ctrl #(.ADDR_W(AW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] ref_mem [256];
  logic [7:0]  ref_areg;
  logic [31:0] ref_dreg;
  logic        ref_err;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    expect_eq({tag, ".areg"}, 32'(MonAReg), 32'(ref_areg));
    expect_eq({tag, ".dreg"}, MonDReg, ref_dreg);
    expect_eq({tag, ".err"}, 32'(monitor_error), 32'(ref_err));
    expect_eq({tag, ".rdy"}, 32'(monitor_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    expect_eq({tag, ".dreg"}, MonDReg, 32'h0);
    expect_eq({tag, ".areg"}, 32'(MonAReg), 32'h0);
    expect_eq({tag, ".rdy"}, 32'(monitor_ready), 32'd1);
    expect_eq({tag, ".err"}, 32'(monitor_error), 32'd0);
    expect_eq({tag, ".rddata"}, cpu_readdata, 32'h0);
    expect_eq({tag, ".wait"}, 32'(cpu_waitrequest), 32'd1);
  endtask

  function automatic logic [37:0] mk_addr_jdo(input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] j;
    j[31:0]  = $urandom();
    j[37:32] = 6'($urandom());
    j[35]    = rd;
    j[34]    = clr;
    j[24:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] mk_data_jdo(input logic [31:0] d);
    logic [37:0] j;
    j[31:0]  = $urandom();
    j[37:32] = 6'($urandom());
    j[34:3]  = d;
    return j;
  endfunction

  // called one cycle after a read-type strobe: two busy cycles, then the result
  task automatic dbg_read_tail(input string tag);
    expect_eq({tag, ".busy1"}, 32'(monitor_ready), 32'd0);
    tick();
    expect_eq({tag, ".busy2"}, 32'(monitor_ready), 32'd0);
    tick();
    ref_dreg = ref_mem[ref_areg];
    ref_areg = ref_areg + 8'd1;
    check_regs(tag);
  endtask

  task automatic dbg_addr(input logic [7:0] a, input logic rd, input logic clr, input string tag);
    jdo = mk_addr_jdo(a, rd, clr);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    ref_areg = a;
    if (clr) ref_err = 1'b0;
    if (rd) begin
      dbg_read_tail(tag);
    end else begin
      expect_eq({tag, ".busy"}, 32'(monitor_ready), 32'd0);
      tick();
      check_regs(tag);
    end
  endtask

  task automatic dbg_write(input logic [31:0] d, input string tag);
    jdo = mk_data_jdo(d);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    expect_eq({tag, ".busy"}, 32'(monitor_ready), 32'd0);
    tick();
    ref_mem[ref_areg] = d;
    ref_dreg = d;
    ref_areg = ref_areg + 8'd1;
    check_regs(tag);
  endtask

  task automatic dbg_next(input string tag);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    dbg_read_tail(tag);
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input string tag);
    cpu_address   = a;
    cpu_writedata = d;
    cpu_write     = 1'b1;
    #1;
    expect_eq({tag, ".wait"}, 32'(cpu_waitrequest), 32'd0);
    tick();
    cpu_write  = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic cpu_rd(input logic [7:0] a, input string tag);
    cpu_address = a;
    cpu_read    = 1'b1;
    #1;
    expect_eq({tag, ".wait1"}, 32'(cpu_waitrequest), 32'd1);
    tick();
    expect_eq({tag, ".wait2"}, 32'(cpu_waitrequest), 32'd0);
    expect_eq({tag, ".data"}, cpu_readdata, ref_mem[a]);
    cpu_read = 1'b0;
    tick();
    check_regs(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    cpu_read = 1'b0;
    cpu_write = 1'b1;   // a write request during reset must stay stalled
    cpu_address = '0;
    cpu_writedata = 32'hBAD0_BAD0;
    tick();
    tick();
    #1;
    check_reset_outputs("reset");
    tick();
    reset = 1'b0;
    cpu_write = 1'b0;
    ref_areg = 8'h00;
    ref_dreg = 32'h0;
    ref_err  = 1'b0;

    // preload every word from the CPU side; the first write lands right after reset
    for (int i = 0; i < 256; i++) begin
      cpu_wr(8'(i), $urandom(), "preload");
    end

    // write then read back through the debug path
    dbg_addr(8'h10, 1'b0, 1'b0, "wr_rd.addr");
    dbg_write(32'hDEAD_BEEF, "wr_rd.data");
    dbg_addr(8'h10, 1'b1, 1'b0, "wr_rd.read");
    expect_eq("wr_rd.dreg_const", MonDReg, 32'hDEAD_BEEF);
    expect_eq("wr_rd.areg_const", 32'(MonAReg), 32'h11);

    // address wrap
    dbg_addr(8'hFF, 1'b0, 1'b0, "wrap.addr");
    dbg_write(32'h1234_5678, "wrap.data");
    expect_eq("wrap.areg_const", 32'(MonAReg), 32'h00);
    cpu_rd(8'hFF, "wrap.cpu_rd");

    // overrun: data-write strobe while a read is in flight
    dbg_addr(8'h70, 1'b0, 1'b0, "ovr.addr");
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    jdo = mk_data_jdo(32'hCAFE_F00D);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    expect_eq("ovr.busy", 32'(monitor_ready), 32'd0);
    tick();
    ref_dreg = ref_mem[ref_areg];
    ref_areg = ref_areg + 8'd1;
    ref_err  = 1'b1;
    check_regs("ovr.done");
    cpu_rd(8'h71, "ovr.nowrite");
    dbg_addr(8'h80, 1'b0, 1'b1, "ovr.clear");

    // collision: CPU write stalls behind a debug read, then completes
    dbg_addr(8'h40, 1'b0, 1'b0, "col.addr");
    cpu_address   = 8'h20;
    cpu_writedata = 32'hA5A5_A5A5;
    cpu_write     = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    #1;
    expect_eq("col.wait0", 32'(cpu_waitrequest), 32'd1);
    tick();
    take_no_action_ocimem_a = 1'b0;
    expect_eq("col.wait1", 32'(cpu_waitrequest), 32'd1);
    tick();
    expect_eq("col.wait2", 32'(cpu_waitrequest), 32'd1);
    tick();
    expect_eq("col.wait3", 32'(cpu_waitrequest), 32'd0);
    ref_dreg = ref_mem[8'h40];
    ref_areg = 8'h41;
    check_regs("col.dbg");
    ref_mem[8'h20] = 32'hA5A5_A5A5;
    tick();
    cpu_write = 1'b0;
    cpu_rd(8'h20, "col.cpu_rd");

    // strobe coincidence: only the address load happens
    jdo = mk_addr_jdo(8'h30, 1'b0, 1'b0);
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    ref_areg = 8'h30;
    ref_err  = 1'b1;
    expect_eq("coin.busy", 32'(monitor_ready), 32'd0);
    tick();
    check_regs("coin.done");
    cpu_rd(8'h30, "coin.nowrite30");
    cpu_rd(8'h41, "coin.nowrite41");

    // reset in the read-latency cycle
    dbg_addr(8'h55, 1'b0, 1'b0, "rst.addr");
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check_reset_outputs("rst.async");
    tick();
    check_reset_outputs("rst.held");
    reset = 1'b0;
    ref_areg = 8'h00;
    ref_dreg = 32'h0;
    ref_err  = 1'b0;
    dbg_addr(8'h55, 1'b1, 1'b0, "rst.after");

    // randomized transactions
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0: dbg_addr(8'($urandom()), 1'($urandom()), 1'($urandom()), "rnd.addr");
        1: dbg_write($urandom(), "rnd.write");
        2: dbg_next("rnd.next");
        3: cpu_wr(8'($urandom()), $urandom(), "rnd.cpu_wr");
        default: cpu_rd(8'($urandom()), "rnd.cpu_rd");
      endcase
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
